// File: rtl/iq_frontend_pkg.sv
// Shared types and arithmetic helpers for the IQ front end.
// Holds the accumulator FSM state enum and a signed saturating add.
package iq_frontend_pkg;

  typedef enum logic [0:0] {
    WAIT_SYNC = 1'b0,
    ACCUM     = 1'b1
  } acc_state_t;

  // Wide enough for any product/accumulator width used with these helpers.
  localparam int SAT_CALC_WIDTH = 64;

  typedef struct packed {
    logic [SAT_CALC_WIDTH-1:0] sum;
    logic                      overflow;
  } sat_result_t;

  // Adds a and b, then clamps the sum to the signed range of 'width' bits.
  function automatic sat_result_t sat_add(input logic signed [SAT_CALC_WIDTH-1:0] a,
                                          input logic signed [SAT_CALC_WIDTH-1:0] b,
                                          input int width);
    logic signed [SAT_CALC_WIDTH:0] full;
    logic signed [SAT_CALC_WIDTH:0] max_v;
    logic signed [SAT_CALC_WIDTH:0] min_v;
    sat_result_t r;
    full  = {a[SAT_CALC_WIDTH-1], a} + {b[SAT_CALC_WIDTH-1], b};
    max_v = (65'sd1 <<< (width - 1)) - 65'sd1;
    min_v = -(65'sd1 <<< (width - 1));
    r.sum      = full[SAT_CALC_WIDTH-1:0];
    r.overflow = 1'b0;
    if (full > max_v) begin
      r.sum      = max_v[SAT_CALC_WIDTH-1:0];
      r.overflow = 1'b1;
    end else if (full < min_v) begin
      r.sum      = min_v[SAT_CALC_WIDTH-1:0];
      r.overflow = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_accumulator.sv
// Signed saturating accumulator: LOAD starts a fresh sum, ADD accumulates.
// OVERFLOW is sticky until the next LOAD.
module sat_accumulator
  import iq_frontend_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int IN_WIDTH  = 25
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        CE,
  input  logic                        LOAD,
  input  logic                        ADD,
  input  logic signed [IN_WIDTH-1:0]  DIN,
  output logic signed [ACC_WIDTH-1:0] ACC,
  output logic                        OVERFLOW
);

  logic signed [SAT_CALC_WIDTH-1:0] din_wide;
  logic signed [SAT_CALC_WIDTH-1:0] base_wide;
  sat_result_t                      res;
  logic signed [ACC_WIDTH-1:0]      acc_next;

  // A load is a saturating add onto zero, so an oversized product is clamped too.
  always_comb begin
    din_wide  = SAT_CALC_WIDTH'(DIN);
    base_wide = LOAD ? '0 : SAT_CALC_WIDTH'(ACC);
    res       = sat_add(base_wide, din_wide, ACC_WIDTH);
    acc_next  = ACC_WIDTH'(res.sum);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ACC      <= '0;
      OVERFLOW <= 1'b0;
    end else if (CE) begin
      if (LOAD) begin
        ACC      <= acc_next;
        OVERFLOW <= res.overflow;
      end else if (ADD) begin
        ACC      <= acc_next;
        OVERFLOW <= OVERFLOW | res.overflow;
      end
    end
  end

endmodule

// File: rtl/iq_period_accumulator.sv
// Multiplies ADC samples by DCO sin/cos and sums them over N DCO periods.
// Stage 1 registers products and the wrap flag; stage 2 runs the window FSM.
module iq_period_accumulator
  import iq_frontend_pkg::*;
#(
  parameter int ADC_DATA_WIDTH       = 12,
  parameter int SIN_TABLE_DATA_WIDTH = 13,
  parameter int MUL_ACC_WIDTH        = 32,
  parameter int PERIOD_COUNT_BITS    = 4,
  parameter int SAMPLE_COUNT_BITS    = 16
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   CE,
  input  logic signed [ADC_DATA_WIDTH-1:0]       ADC_VALUE,
  input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] SIN_VALUE,
  input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] COS_VALUE,
  input  logic                                   PHASE_WRAP,
  input  logic [PERIOD_COUNT_BITS-1:0]           PERIODS_PER_RESULT,
  output logic signed [MUL_ACC_WIDTH-1:0]        SIN_ACC_OUT,
  output logic signed [MUL_ACC_WIDTH-1:0]        COS_ACC_OUT,
  output logic [SAMPLE_COUNT_BITS-1:0]           SAMPLE_COUNT_OUT,
  output logic                                   RESULT_VALID,
  output logic                                   OVERFLOW,
  output logic                                   SYNCED,
  output acc_state_t                             DEBUG_STATE
);

  localparam int PROD_WIDTH = ADC_DATA_WIDTH + SIN_TABLE_DATA_WIDTH;

  logic signed [PROD_WIDTH-1:0]        sin_prod;
  logic signed [PROD_WIDTH-1:0]        cos_prod;
  logic                                wrap_s1;
  acc_state_t                          state;
  acc_state_t                          state_next;
  logic                                acc_load;
  logic                                acc_add;
  logic                                close_window;
  logic [PERIOD_COUNT_BITS-1:0]        period_cnt;
  logic [PERIOD_COUNT_BITS-1:0]        n_latched;
  logic [SAMPLE_COUNT_BITS-1:0]        sample_cnt;
  logic signed [MUL_ACC_WIDTH-1:0]     sin_acc;
  logic signed [MUL_ACC_WIDTH-1:0]     cos_acc;
  logic                                sin_ovf;
  logic                                cos_ovf;

  assign DEBUG_STATE = state;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sin_prod <= '0;
      cos_prod <= '0;
      wrap_s1  <= 1'b0;
    end else if (CE) begin
      sin_prod <= PROD_WIDTH'(ADC_VALUE) * PROD_WIDTH'(SIN_VALUE);
      cos_prod <= PROD_WIDTH'(ADC_VALUE) * PROD_WIDTH'(COS_VALUE);
      wrap_s1  <= PHASE_WRAP;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) state <= WAIT_SYNC;
    else if (CE) state <= state_next;
  end

  // A closing wrap reloads the accumulators with its own products, so the
  // wrap sample belongs to the new window rather than the reported one.
  always_comb begin
    state_next   = state;
    acc_load     = 1'b0;
    acc_add      = 1'b0;
    close_window = 1'b0;
    case (state)
      WAIT_SYNC: begin
        if (wrap_s1) begin
          state_next = ACCUM;
          acc_load   = 1'b1;
        end
      end
      ACCUM: begin
        if (wrap_s1 && (period_cnt == n_latched)) begin
          close_window = 1'b1;
          acc_load     = 1'b1;
        end else begin
          acc_add = 1'b1;
        end
      end
      default: state_next = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      period_cnt       <= '0;
      n_latched        <= '0;
      sample_cnt       <= '0;
      SIN_ACC_OUT      <= '0;
      COS_ACC_OUT      <= '0;
      SAMPLE_COUNT_OUT <= '0;
      OVERFLOW         <= 1'b0;
      RESULT_VALID     <= 1'b0;
      SYNCED           <= 1'b0;
    end else begin
      RESULT_VALID <= 1'b0;
      if (CE) begin
        if (acc_load) begin
          period_cnt <= PERIOD_COUNT_BITS'(1);
          sample_cnt <= SAMPLE_COUNT_BITS'(1);
          n_latched  <= (PERIODS_PER_RESULT == '0) ? PERIOD_COUNT_BITS'(1) : PERIODS_PER_RESULT;
          SYNCED     <= 1'b1;
        end else if (acc_add) begin
          if (sample_cnt != '1) sample_cnt <= sample_cnt + SAMPLE_COUNT_BITS'(1);
          if (wrap_s1) period_cnt <= period_cnt + PERIOD_COUNT_BITS'(1);
        end
        if (close_window) begin
          SIN_ACC_OUT      <= sin_acc;
          COS_ACC_OUT      <= cos_acc;
          SAMPLE_COUNT_OUT <= sample_cnt;
          OVERFLOW         <= sin_ovf | cos_ovf;
          RESULT_VALID     <= 1'b1;
        end
      end
    end
  end

  sat_accumulator #(
    .ACC_WIDTH (MUL_ACC_WIDTH),
    .IN_WIDTH  (PROD_WIDTH)
  ) u_sin_acc (
    .CLK      (CLK),
    .RESET    (RESET),
    .CE       (CE),
    .LOAD     (acc_load),
    .ADD      (acc_add),
    .DIN      (sin_prod),
    .ACC      (sin_acc),
    .OVERFLOW (sin_ovf)
  );

  sat_accumulator #(
    .ACC_WIDTH (MUL_ACC_WIDTH),
    .IN_WIDTH  (PROD_WIDTH)
  ) u_cos_acc (
    .CLK      (CLK),
    .RESET    (RESET),
    .CE       (CE),
    .LOAD     (acc_load),
    .ADD      (acc_add),
    .DIN      (cos_prod),
    .ACC      (cos_acc),
    .OVERFLOW (cos_ovf)
  );

endmodule

// File: tb/tb_iq_period_accumulator.sv
// Bench for iq_period_accumulator: a default instance and a narrow one
// (24-bit sums, 4-bit sample count) share stimulus; results go through queues.
module tb_iq_period_accumulator;
  import iq_frontend_pkg::*;

  // Result handshake: RESULT_VALID is a one-cycle pulse; the outputs it
  // qualifies hold their value until the next pulse. There is no ready.

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n = 1'b0;
  logic               ce    = 1'b0;
  logic               wrap  = 1'b0;
  logic signed [11:0] adc   = '0;
  logic signed [12:0] sin_v = '0;
  logic signed [12:0] cos_v = '0;
  logic [3:0]         ppr   = '0;

  logic signed [31:0] sin_a, cos_a;
  logic [15:0]        cnt_a;
  logic               valid_a, ovf_a, sync_a;
  acc_state_t         st_a;
  logic signed [23:0] sin_b, cos_b;
  logic [3:0]         cnt_b;
  logic               valid_b, ovf_b, sync_b;
  acc_state_t         st_b;

  iq_period_accumulator u_dut_a (
    .CLK(clk), .RESET(rst_n), .CE(ce), .ADC_VALUE(adc), .SIN_VALUE(sin_v),
    .COS_VALUE(cos_v), .PHASE_WRAP(wrap), .PERIODS_PER_RESULT(ppr),
    .SIN_ACC_OUT(sin_a), .COS_ACC_OUT(cos_a), .SAMPLE_COUNT_OUT(cnt_a),
    .RESULT_VALID(valid_a), .OVERFLOW(ovf_a), .SYNCED(sync_a), .DEBUG_STATE(st_a)
  );

  iq_period_accumulator #(.MUL_ACC_WIDTH(24), .SAMPLE_COUNT_BITS(4)) u_dut_b (
    .CLK(clk), .RESET(rst_n), .CE(ce), .ADC_VALUE(adc), .SIN_VALUE(sin_v),
    .COS_VALUE(cos_v), .PHASE_WRAP(wrap), .PERIODS_PER_RESULT(ppr),
    .SIN_ACC_OUT(sin_b), .COS_ACC_OUT(cos_b), .SAMPLE_COUNT_OUT(cnt_b),
    .RESULT_VALID(valid_b), .OVERFLOW(ovf_b), .SYNCED(sync_b), .DEBUG_STATE(st_b)
  );

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] c;
    logic [15:0] cnt;
    logic        ovf;
    logic [31:0] at;
  } exp_t;

  exp_t  exp_a_q[$];
  exp_t  exp_b_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  longint ps[2], pc[2], pn[2];
  logic   po[2];
  logic   prev_rst = 1'b0;

  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual no finish, required finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic mon(input int id, input logic v, input longint s, input longint c,
                     input longint n, input logic o);
    exp_t e;
    if (v) begin
      if ((id == 0 && exp_a_q.size() == 0) || (id == 1 && exp_b_q.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result dut%0d: actual RESULT_VALID=1, required 0", id);
      end else begin
        if (id == 0) e = exp_a_q.pop_front();
        else         e = exp_b_q.pop_front();
        check($sformatf("sin_acc dut%0d", id), s, longint'($signed(e.s)));
        check($sformatf("cos_acc dut%0d", id), c, longint'($signed(e.c)));
        check($sformatf("sample_count dut%0d", id), n, longint'(e.cnt));
        check($sformatf("overflow dut%0d", id), longint'(o), longint'(e.ovf));
        check($sformatf("pulse_cycle dut%0d", id), longint'(cyc), longint'(e.at));
      end
    end else if (rst_n && prev_rst) begin
      check($sformatf("outputs_hold dut%0d", id),
            longint'(s == ps[id] && c == pc[id] && n == pn[id] && o == po[id]), 1);
    end
    ps[id] = s;
    pc[id] = c;
    pn[id] = n;
    po[id] = o;
  endtask

  always @(negedge clk) begin
    mon(0, valid_a, longint'(sin_a), longint'(cos_a), longint'(cnt_a), ovf_a);
    mon(1, valid_b, longint'(sin_b), longint'(cos_b), longint'(cnt_b), ovf_b);
    prev_rst = rst_n;
  end

  // ---------------- driver tasks ----------------
  // One CE=1 sample; with toggle, a CE=0 cycle of junk inputs follows.
  // 'at' is the cycle the result pulse appears if this sample closes a window.
  task automatic send(input int a, input int s, input int c, input bit w, input int p,
                      input bit toggle, output int at);
    ce = 1'b1; adc = 12'(a); sin_v = 13'(s); cos_v = 13'(c); wrap = w; ppr = 4'(p);
    @(posedge clk); #1;
    at = cyc + 1;
    if (toggle) begin
      ce    = 1'b0;
      adc   = 12'($urandom_range(0, 4095));
      sin_v = 13'($urandom_range(0, 8191));
      cos_v = 13'($urandom_range(0, 8191));
      wrap  = 1'($urandom_range(0, 1));
      ppr   = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      at = cyc + 1;
    end
  endtask

  task automatic push(input int at, input longint sa, input longint ca, input longint sb,
                      input longint cb, input bit oa, input bit ob, input int n);
    exp_a_q.push_back('{s: 32'(sa), c: 32'(ca), cnt: 16'(n), ovf: oa, at: 32'(at)});
    exp_b_q.push_back('{s: 32'(sb), c: 32'(cb), cnt: 16'((n > 15) ? 15 : n), ovf: ob, at: 32'(at)});
  endtask

  task automatic drain();
    int at;
    repeat (3) send(0, 0, 0, 1'b0, 1, 1'b0, at);
    ce = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " sin dutA"}, longint'(sin_a), 0);
    check({tag, " cos dutA"}, longint'(cos_a), 0);
    check({tag, " count dutA"}, longint'(cnt_a), 0);
    check({tag, " overflow dutA"}, longint'(ovf_a), 0);
    check({tag, " synced dutA"}, longint'(sync_a), 0);
    check({tag, " state dutA"}, longint'(st_a), longint'(WAIT_SYNC));
    check({tag, " sin dutB"}, longint'(sin_b), 0);
    check({tag, " cos dutB"}, longint'(cos_b), 0);
    check({tag, " count dutB"}, longint'(cnt_b), 0);
    check({tag, " synced dutB"}, longint'(sync_b), 0);
  endtask

  // Reset with random CE, then idle with CE=0 while wraps toggle: nothing may move.
  task automatic do_reset();
    rst_n = 1'b0;
    ce    = 1'($urandom_range(0, 1));
    wrap  = 1'b1;
    adc   = 12'sd100;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    ce    = 1'b0;
    check_zero("reset");
    repeat (4) begin
      wrap = 1'($urandom_range(0, 1));
      adc  = 12'($urandom_range(0, 4095));
      @(posedge clk); #1;
    end
    check("ce_low valid dutA", longint'(valid_a), 0);
    check("ce_low synced dutA", longint'(sync_a), 0);
    check("ce_low synced dutB", longint'(sync_b), 0);
  endtask

  // Constant stimulus with a wrap every 'period' samples; every window gives
  // esum / -esum over ecnt samples.
  task automatic run_periodic(input int a, input int s, input int c, input int period,
                              input int p, input int nwraps, input bit toggle,
                              input bit jitter, input longint esum, input int ecnt);
    int neff;
    int at;
    int pv;
    bit w;
    neff = (p == 0) ? 1 : p;
    for (int i = 0; i <= nwraps * period; i++) begin
      w  = ((i % period) == 0);
      pv = (jitter && (i % period) >= 3 && (i % period) <= period - 3)
           ? int'($urandom_range(0, 15)) : p;
      send(a, s, c, w, pv, toggle, at);
      if (w && i > 0 && ((i / period) % neff) == 0)
        push(at, esum, -esum, esum, -esum, 1'b0, 1'b0, ecnt);
      if (i == 2) begin
        check("synced dutA", longint'(sync_a), 1);
        check("synced dutB", longint'(sync_b), 1);
      end
    end
    drain();
  endtask

  initial begin
    int at;
    int a;

    // 100*10 per sample, 40 samples per period
    do_reset();
    run_periodic(100, 10, -10, 40, 1, 3, 1'b0, 1'b0, 40000, 40);

    // four periods per result; PERIODS_PER_RESULT jitters mid-window
    do_reset();
    run_periodic(100, 10, -10, 40, 4, 8, 1'b0, 1'b1, 160000, 160);

    // zero periods behaves as one
    do_reset();
    run_periodic(100, 10, -10, 40, 0, 2, 1'b0, 1'b0, 40000, 40);

    // CE at 50%: sums and counts unchanged
    do_reset();
    run_periodic(100, 10, -10, 40, 1, 3, 1'b1, 1'b0, 40000, 40);

    // saturation: 2047*4095 = 8382465 per sample, 8 samples per window
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      a = (i < 8) ? 2047 : 0;
      send(a, 4095, -4095, (i % 8) == 0, 1, 1'b0, at);
      if (i == 8)  push(at, 67059720, -67059720, 8388607, -8388608, 1'b0, 1'b1, 8);
      if (i == 16) push(at, 0, 0, 0, 0, 1'b0, 1'b0, 8);
    end
    drain();

    // reset mid-window: partial window dropped, resync on the next wrap
    do_reset();
    for (int i = 0; i < 60; i++) begin
      send(100, 10, -10, (i % 40) == 0, 1, 1'b0, at);
      if (i == 40) push(at, 40000, -40000, 40000, -40000, 1'b0, 1'b0, 40);
    end
    rst_n = 1'b0;
    wrap  = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    check("mid_reset sin dutA", longint'(sin_a), 0);
    check("mid_reset count dutA", longint'(cnt_a), 0);
    check("mid_reset synced dutA", longint'(sync_a), 0);
    check("mid_reset sin dutB", longint'(sin_b), 0);
    for (int i = 60; i <= 160; i++) begin
      send(100, 10, -10, (i % 40) == 0, 1, 1'b0, at);
      if ((i % 40) == 0 && i >= 120) push(at, 40000, -40000, 40000, -40000, 1'b0, 1'b0, 40);
    end
    drain();

    repeat (5) begin @(posedge clk); #1; end
    check("pending results dutA", longint'(exp_a_q.size()), 0);
    check("pending results dutB", longint'(exp_b_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iq_period_accumulator.md
IQ_PERIOD_ACCUMULATOR -- requirements
Module: iq_period_accumulator

Interface
REQ-001 SHALL have parameter ADC_DATA_WIDTH, default 12, signed ADC sample width.
REQ-002 SHALL have parameter SIN_TABLE_DATA_WIDTH, default 13, signed sin/cos width.
REQ-003 SHALL have parameter MUL_ACC_WIDTH, default 32, signed accumulator and result width.
REQ-004 SHALL have parameter PERIOD_COUNT_BITS, default 4, width of the periods-per-result control.
REQ-005 SHALL have parameter SAMPLE_COUNT_BITS, default 16, width of the sample counter.
REQ-006 SHALL have port CLK, input, 1, sole clock, all logic on rising edge.
REQ-007 SHALL have port RESET, input, 1, synchronous active-low reset (0 = reset).
REQ-008 SHALL have port CE, input, 1, clock enable; pipeline advances only when CE=1.
REQ-009 SHALL have port ADC_VALUE, input, ADC_DATA_WIDTH, signed ADC sample.
REQ-010 SHALL have ports SIN_VALUE and COS_VALUE, input, SIN_TABLE_DATA_WIDTH each, signed DCO outputs aligned with ADC_VALUE.
REQ-011 SHALL have port PHASE_WRAP, input, 1, DCO phase wrap flag aligned with SIN_VALUE; the sample carrying it starts a new period.
REQ-012 SHALL have port PERIODS_PER_RESULT, input, PERIOD_COUNT_BITS, periods per result window; 0 treated as 1.
REQ-013 SHALL have ports SIN_ACC_OUT and COS_ACC_OUT, output, MUL_ACC_WIDTH each, signed window sums.
REQ-014 SHALL have port SAMPLE_COUNT_OUT, output, SAMPLE_COUNT_BITS, samples in the reported window.
REQ-015 SHALL have ports RESULT_VALID (1-cycle pulse), OVERFLOW (window saturated) and SYNCED (first wrap seen), output, 1 each.

Function
REQ-016 SHALL implement a 2-stage pipeline: stage 1 registers ADC*SIN, ADC*COS and the wrap flag; stage 2 accumulates.
REQ-017 SHALL have states WAIT_SYNC (discard products) and ACCUM; WAIT_SYNC->ACCUM on the first stage-1 wrap; no other transition except reset.
REQ-018 SHALL, on entering ACCUM, load accumulators with the wrap sample's products, sample count 1, period count 1, and latch PERIODS_PER_RESULT as N.
REQ-019 SHALL, on a stage-1 wrap in ACCUM with period count = N, copy accumulators (excluding the wrap sample), sample count and overflow flag to outputs, pulse RESULT_VALID, and restart the window as REQ-018.
REQ-020 SHALL, on a stage-1 wrap with period count < N, increment period count and keep accumulating the wrap sample.
REQ-021 SHALL assert RESULT_VALID at the clock edge 2 CE-cycles after the CE-cycle presenting the window-closing PHASE_WRAP.
REQ-022 SHALL deassert RESULT_VALID on the next clock edge regardless of CE.
REQ-023 SHALL hold outputs stable between RESULT_VALID pulses.
REQ-024 SHALL saturate each accumulator to the signed MUL_ACC_WIDTH range, set a per-window sticky overflow, and clear it at window restart.
REQ-025 SHALL saturate the sample counter at all-ones, never wrapping.
REQ-026 SHALL ignore PERIODS_PER_RESULT changes until the next window start.
REQ-027 SHALL freeze all state when CE=0; CE-gaps shall not change sums.

Reset
REQ-028 SHALL, while RESET=0 at a clock edge, clear all state and outputs to 0, state to WAIT_SYNC, SYNCED=0, regardless of CE.
REQ-029 SHALL, after reset release mid-window, discard the partial window and produce no RESULT_VALID before one full window after the next wrap.

Structure
REQ-030 SHALL place the state enum and a signed saturating-add function in a shared package iq_frontend_pkg.
REQ-031 SHALL instantiate one sub-module sat_accumulator twice (sin and cos), providing load, add, saturation and overflow.

Verification
REQ-032 SHALL check after reset: all outputs 0, SYNCED=0, no RESULT_VALID with CE=0.
REQ-033 SHALL check ADC=100, SIN=10, COS=-10, wrap every 40 CE-cycles, N=1 -> SIN_ACC_OUT=40000, COS_ACC_OUT=-40000, SAMPLE_COUNT_OUT=40, RESULT_VALID every 40 cycles.
REQ-034 SHALL check the same stimulus with N=4 -> 160000 / -160000 / 160, pulse every 160 cycles; N=0 behaves as N=1.
REQ-035 SHALL check MUL_ACC_WIDTH=24, ADC=2047, SIN=4095, wrap every 8 -> SIN_ACC_OUT=8388607, OVERFLOW=1; next window with ADC=0 -> 0, OVERFLOW=0.
REQ-036 SHALL check CE toggled 50% with REQ-033 stimulus -> identical sums and counts.
REQ-037 SHALL check RESET=0 pulse mid-window -> outputs 0, then first RESULT_VALID exactly one window after the next wrap.
